// File: rtl/led_fade_driver.sv
// led_fade_driver: eight-channel PWM output stage with a linear fade-out tail.
// A request drives its channel to full brightness. Once the request is released,
// the channel decays by one step every FADE_DIV PWM periods until it is dark.
// The LED outputs are active-low.
// Optional feature macro: LED_FADE_IN_EN. When it is defined, a held request
// ramps the level up by one step per fade tick instead of jumping to full.
// There is no handshake: led_req is a level that is sampled every clock, and no
// valid/ready pair exists on this block.
module led_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] led_req,
  output logic [7:0] led_n,
  output logic       period_start,
  output logic       active
);

  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
  localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_DIV - 1);
  localparam logic [FW-1:0]       FADE_ONE  = FW'(1);

  logic [7:0]          req_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FW-1:0]       fade_cnt;
  logic [PWM_BITS-1:0] level     [8];
  logic [PWM_BITS-1:0] level_nxt [8];
  logic [7:0]          pwm_on;
  logic                pe;
  logic                ft;
  logic                any_lit;

  // The period ends on the last count. A fade tick is every FADE_DIV-th period end.
  assign pe = (pwm_cnt == LVL_MAX);
  assign ft = pe && (fade_cnt == FADE_LAST);

  // Next level per channel. Levels move only at a period end, so the duty cycle
  // never changes part-way through a PWM period.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_nxt[i] = level[i];
      if (pe) begin
        if (req_q[i]) begin
`ifdef LED_FADE_IN_EN
          if (ft && (level[i] != LVL_MAX)) level_nxt[i] = level[i] + LVL_ONE;
`else
          level_nxt[i] = LVL_MAX;
`endif
        end else if (ft && (level[i] != '0)) begin
          level_nxt[i] = level[i] - LVL_ONE;
        end
      end
    end
  end

  // PWM compare and the any-channel-lit reduction, both taken from the current levels.
  always_comb begin
    pwm_on  = '0;
    any_lit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pwm_on[i] = (pwm_cnt < level[i]);
      if (level[i] != '0) any_lit = 1'b1;
    end
  end

  // State registers. Every output is registered, so led_n lags pwm_cnt by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      pwm_cnt      <= '0;
      fade_cnt     <= '0;
      led_n        <= 8'hFF;
      period_start <= 1'b0;
      active       <= 1'b0;
      for (int i = 0; i < 8; i++) level[i] <= '0;
    end else begin
      req_q   <= led_req;
      pwm_cnt <= pwm_cnt + LVL_ONE;
      if (pe) fade_cnt <= ft ? '0 : fade_cnt + FADE_ONE;
      for (int i = 0; i < 8; i++) level[i] <= level_nxt[i];
      led_n        <= ~pwm_on;
      period_start <= pe;
      active       <= any_lit;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed testbench for led_fade_driver.
// Instance A uses the default widths (256-clock period, 16 periods per fade step).
// Instance B is a small build (16-clock period, 2 periods per fade step), so that
// a full decay, or a full ramp when LED_FADE_IN_EN is defined, completes quickly.
// Each channel's level is read back as the number of low led_n samples in one period.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_req_a, led_req_b;
  logic [7:0] led_n_a, led_n_b;
  logic       period_start_a, period_start_b;
  logic       active_a, active_b;

  int tests = 0;
  int fails = 0;
  int cnt_a [8];
  int cnt_b [8];
  int n;

  // Clock
  always #5 clk = ~clk;

  led_fade_driver #(.PWM_BITS(8), .FADE_DIV(16)) dut_a (
    .clk(clk), .rst(rst), .led_req(led_req_a),
    .led_n(led_n_a), .period_start(period_start_a), .active(active_a)
  );

  led_fade_driver #(.PWM_BITS(4), .FADE_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .led_req(led_req_b),
    .led_n(led_n_b), .period_start(period_start_b), .active(active_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts the low led_n samples over one period of A. Entry and exit points are
  // both just after a period_start edge.
  task automatic measure_a();
    for (int i = 0; i < 8; i++) cnt_a[i] = 0;
    repeat (256) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) if (led_n_a[i] === 1'b0) cnt_a[i]++;
    end
    check("period_align_a", period_start_a, 1);
  endtask

  task automatic measure_b();
    for (int i = 0; i < 8; i++) cnt_b[i] = 0;
    repeat (16) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) if (led_n_b[i] === 1'b0) cnt_b[i]++;
    end
    check("period_align_b", period_start_b, 1);
  endtask

  task automatic wait_ps_a(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (period_start_a !== 1'b1 && cycles < 1000);
  endtask

  task automatic wait_ps_b(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (period_start_b !== 1'b1 && cycles < 1000);
  endtask

  initial begin
    rst       = 1'b1;
    led_req_a = 8'h00;
    led_req_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_n_a", led_n_a, 8'hFF);
    check("rst_ps_a", period_start_a, 0);
    check("rst_active_a", active_a, 0);
    check("rst_led_n_b", led_n_b, 8'hFF);
    check("rst_active_b", active_b, 0);

`ifndef LED_FADE_IN_EN
    // Release: the first period_start comes exactly 256 clocks later.
    rst = 1'b0;
    wait_ps_a(n);
    check("first_ps_a", n, 256);

    // Instant on: a request in P1 gives full level during P2.
    led_req_a = 8'h01;
    measure_a();
    check("p1_ch0", cnt_a[0], 0);
    measure_a();
    check("p2_ch0", cnt_a[0], 255);
    check("p2_ch1", cnt_a[1], 0);
    check("p2_active", active_a, 1);

    // Decay: fade ticks fall on period ends 16, 32, ...
    led_req_a = 8'h00;
    for (int p = 3; p <= 32; p++) begin
      measure_a();
      if (p == 15) check("p15_ch0", cnt_a[0], 255);
      if (p == 16) check("p16_ch0", cnt_a[0], 254);
      if (p == 31) check("p31_ch0", cnt_a[0], 254);
      if (p == 32) check("p32_ch0", cnt_a[0], 253);
    end

    // Short pulse that lies wholly inside P33 must be ignored.
    fork
      begin
        repeat (20) @(posedge clk);
        #1 led_req_a[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1 led_req_a[3] = 1'b0;
      end
    join_none
    measure_a();
    check("p33_ch0", cnt_a[0], 253);

    // The same pulse straddling the P34/P35 boundary must be honoured.
    fork
      begin
        repeat (250) @(posedge clk);
        #1 led_req_a[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1 led_req_a[3] = 1'b0;
      end
    join_none
    measure_a();
    check("p34_ch3_short_ignored", cnt_a[3], 0);

    // Chaser: bit 1 is held for 50 periods, then bit 2 for 50 periods.
    led_req_a[1] = 1'b1;
    measure_a();
    check("p35_ch3_straddle", cnt_a[3], 255);
    check("p35_ch1", cnt_a[1], 0);
    for (int p = 36; p <= 84; p++) begin
      measure_a();
      if (p == 36) check("p36_ch1", cnt_a[1], 255);
      if (p == 48) check("p48_ch0", cnt_a[0], 252);
      if (p == 48) check("p48_ch3", cnt_a[3], 254);
    end
    led_req_a = 8'h04;
    for (int p = 85; p <= 134; p++) begin
      measure_a();
      if (p == 85) check("p85_ch1", cnt_a[1], 255);
      if (p == 85) check("p85_ch2", cnt_a[2], 0);
      if (p == 96) check("p96_ch1", cnt_a[1], 254);
      if (p == 128) check("p128_ch1", cnt_a[1], 252);
      if (p == 134) begin
        check("p134_ch1", cnt_a[1], 252);
        check("p134_ch2", cnt_a[2], 255);
        check("p134_ch0", cnt_a[0], 247);
        check("p134_ch3", cnt_a[3], 249);
        check("p134_active", active_a, 1);
      end
    end

    // Reset in mid-period clears everything on the next edge.
    led_req_a = 8'h00;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_led_n_a", led_n_a, 8'hFF);
    check("midrst_ps_a", period_start_a, 0);
    check("midrst_active_a", active_a, 0);
    rst = 1'b0;
    wait_ps_a(n);
    check("midrst_first_ps_a", n, 256);
    measure_a();
    check("midrst_ch2_level", cnt_a[2], 0);
    check("midrst_ch0_level", cnt_a[0], 0);
    check("midrst_active_after", active_a, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif

    rst = 1'b0;
    wait_ps_b(n);
    check("first_ps_b", n, 16);

`ifdef LED_FADE_IN_EN
    // Ramp on channel 5: the level rises by one at each even period end.
    led_req_b = 8'h20;
    measure_b();
    check("ramp_p1_ch5", cnt_b[5], 0);
    for (int p = 2; p <= 17; p++) begin
      measure_b();
      if (p == 2) check("ramp_p2_ch5", cnt_b[5], 1);
      if (p == 3) check("ramp_p3_ch5", cnt_b[5], 1);
      if (p == 16) check("ramp_p16_ch5", cnt_b[5], 8);
    end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("ramp_rst_led_n_b", led_n_b, 8'hFF);
    check("ramp_rst_active_b", active_b, 0);
    rst = 1'b0;
    wait_ps_b(n);
    check("ramp_rst_first_ps_b", n, 16);
    measure_b();
    check("ramp_rst_p1_ch5", cnt_b[5], 0);
    for (int p = 2; p <= 32; p++) begin
      measure_b();
      if (p == 2) check("ramp2_p2_ch5", cnt_b[5], 1);
      if (p == 29) check("ramp2_p29_ch5", cnt_b[5], 14);
      if (p == 30) check("ramp2_p30_ch5", cnt_b[5], 15);
      if (p == 32) check("ramp2_p32_sat", cnt_b[5], 15);
    end
`else
    // Full decay on the small build, ending dark with no wrap-around.
    led_req_b = 8'h80;
    measure_b();
    check("b_p1_ch7", cnt_b[7], 0);
    measure_b();
    check("b_p2_ch7", cnt_b[7], 15);
    led_req_b = 8'h00;
    for (int p = 3; p <= 40; p++) begin
      measure_b();
      if (p == 3) check("b_p3_ch7", cnt_b[7], 15);
      if (p == 4) check("b_p4_ch7", cnt_b[7], 14);
      if (p == 30) check("b_p30_ch7", cnt_b[7], 1);
      if (p == 30) check("b_p30_active", active_b, 1);
      if (p == 32) check("b_p32_ch7", cnt_b[7], 0);
      if (p == 32) check("b_p32_active", active_b, 0);
      if (p == 40) check("b_p40_no_wrap", cnt_b[7], 0);
      if (p == 40) check("b_p40_led_n", led_n_b, 8'hFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream output stage for the LED chaser. It takes the chaser's per-LED on/off requests and drives the eight active-low board LEDs with per-channel PWM brightness. A request turns a channel to full brightness; releasing it decays the channel linearly to dark, giving a fading "comet tail" behind the running light. It runs directly on the `clk` produced by the internal high-speed oscillator at the 6 MHz setting.

## Interface
- `PWM_BITS`, 8: PWM counter and brightness width; PWM period = 2^PWM_BITS clocks.
- `FADE_DIV`, 16: number of PWM periods per one-step brightness change (≥1).
- `clk` input 1: system clock (6 MHz HFOSC). One clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `led_req` input 8: per-LED request, active-high, from the chaser. Asynchronous to nothing (same `clk`), arbitrary toggling allowed.
- `led_n` output 8: LED drive, active-low (0 = lit), registered.
- `period_start` output 1: one-cycle pulse in the first cycle of each PWM period.
- `active` output 1: high when any channel level is nonzero.

## Operation
- Registered state:
  - `req_q[7:0]`: `led_req` sampled every cycle.
  - `pwm_cnt[PWM_BITS-1:0]`: free-running, wraps from 2^PWM_BITS-1 to 0.
  - `fade_cnt`: 0..FADE_DIV-1.
  - `level[i][PWM_BITS-1:0]` per channel.
- Period end (PE) is the cycle where `pwm_cnt == 2^PWM_BITS-1`. `level` changes only on the PE edge, never mid-period, so there are no duty glitches.
- Fade tick (FT) is a PE where `fade_cnt == FADE_DIV-1`. `fade_cnt` increments on every PE and wraps to 0 on FT.
- Per channel at PE, priority top-down:
  - `req_q[i]=1` → `level[i] := 2^PWM_BITS-1` (instant on).
  - `req_q[i]=0` and FT and `level[i]>0` → `level[i] := level[i]-1`.
  - Otherwise hold.
- Decrement saturates at 0; there is no wrap-around.
- PWM: `led_n[i] := ~(pwm_cnt < level[i])`, registered.
  - Duty = level/2^PWM_BITS.
  - Level 0 gives constant `led_n[i]=1`.
  - Maximum level gives 255/256 on at the default width.
- `period_start := (pwm_cnt == 2^PWM_BITS-1)`, registered; it is high while `pwm_cnt == 0`.
- `active := |level` (OR over all channels), registered.
- A request pulse shorter than one period is honoured only if `req_q` is high at the PE edge.
- Simultaneous request and FT on one channel: the request wins and the level goes to max.

## Timing
- Reset values: `led_n=8'hFF`, `period_start=0`, `active=0`, all `level=0`, `pwm_cnt=0`, `fade_cnt=0`, `req_q=0`.
- Reset asserted mid-period or mid-fade clears all of the above on the next edge. The first `period_start` after release occurs 2^PWM_BITS cycles later.
- Request latency: `led_req` rises at edge t → `req_q` at t+1 → `level` max at the next PE edge after t+1 → `led_n` low one cycle after `pwm_cnt` returns to 0 (i.e. 1 cycle after `period_start` rises).
- Worst-case latency is 2^PWM_BITS+2 cycles.
- Full decay from max: (2^PWM_BITS-1) FTs. At the defaults this is 255×16×256 = 1,044,480 cycles ≈ 174 ms.
- `led_n` output lags `pwm_cnt` by exactly 1 cycle.

## Configuration
- `LED_FADE_IN_EN` defined: instant-on is replaced by a ramp. With `req_q[i]=1`, each FT increments `level[i]` by 1, saturating at max; non-FT PEs hold. Release behaviour is unchanged. Simultaneous request and FT: increment.
- `LED_FADE_IN_EN` undefined: instant-on as described in Operation.

## Test plan
Defaults unless noted; fade-in cases use `FADE_DIV=2`.
- Reset: assert `rst` for 3 cycles → `led_n=8'hFF`, `period_start=0`, `active=0`. Release → first `period_start` pulse exactly 256 cycles after release.
- Instant on: hold `led_req=8'h01` → within 258 cycles `level[0]=255`. Then per period, `led_n[0]` is low for 255 cycles and high for 1 cycle, aligned 1 cycle after `period_start`. `active=1`.
- Decay: from `level[0]=255`, drop `led_req` to 0 → `level[0]` decrements by 1 every 16 periods. After 4080 periods, `level[0]=0`, `led_n[0]` is constantly 1 and `active` falls to 0. No wrap to 255.
- Chaser pattern: rotate a one-hot `led_req` through bits 0..7, 50 periods per bit → the previous channel's level decreases by 3 per 50 periods (FT every 16 periods) while the current channel is at 255. No two channels change level mid-period.
- Short pulse: `led_req[3]` high for 10 cycles entirely between PEs → `level[3]` stays 0. The same 10-cycle pulse straddling a PE → `level[3]=255`.
- `LED_FADE_IN_EN` with `FADE_DIV=2`: hold `led_req[5]` → `level[5]` rises by 1 every 2 periods and reaches 255 after 510 periods. Reset mid-ramp → `level[5]=0` on the next edge.
